// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLD      = 2'd3
  } sched_state_t;

  // 50 MHz system clock / 115200 baud
  localparam logic [12:0] BAUD_RESET_DEFAULT = 13'd434;

  // Width of the packet-lock inactivity counter
  localparam int TMO_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, with wrap.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any
);

  logic [IDW:0]   sum_s;
  logic [IDW-1:0] idx_s;

  // Scan from ptr upward, wrapping at N, and keep the first requester found
  always_comb begin
    grant     = {N{1'b0}};
    grant_idx = {IDW{1'b0}};
    any       = 1'b0;
    sum_s     = {(IDW+1){1'b0}};
    idx_s     = {IDW{1'b0}};
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, ptr} + (IDW+1)'(k);
      if (sum_s >= (IDW+1)'(N)) begin
        sum_s = sum_s - (IDW+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[IDW-1:0];
      if (!any && req[idx_s]) begin
        any       = 1'b1;
        grant_idx = idx_s;
      end else begin
        any = any;
      end
    end
    if (any) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = {N{1'b0}};
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX driver between several byte
// streams, with packet locking and a between-frames baud divisor update.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int          NUM_REQ      = 2,
  parameter logic [12:0] BAUD_RESET   = BAUD_RESET_DEFAULT,
  parameter logic [15:0] LOCK_TIMEOUT = 16'd65535,
  parameter int          IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 trmt,
  output logic [7:0]           tx_data,
  input  logic                 ACK_TRMT,
  input  logic                 tx_done,
  input  logic                 cfg_baud_we,
  input  logic [12:0]          cfg_baud_wdata,
  output logic [12:0]          baud_DB,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  sched_state_t       state_r, state_s;
  logic [IDW-1:0]     rr_ptr_r, grant_id_r, load_idx_s, arb_idx_s, next_ptr_s;
  logic [NUM_REQ-1:0] arb_grant_s, req_ready_s;
  logic               arb_any_s, load_s, ptr_adv_s, tmo_clr_s, tmo_inc_s;
  logic               last_r, apply_baud_s;
  logic [7:0]         tx_data_r;
  logic [TMO_W-1:0]   tmo_cnt_r;
  logic [12:0]        pend_baud_r, baud_r;
  logic               pend_flag_r;

  rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .any       (arb_any_s)
  );

  assign next_ptr_s   = (grant_id_r == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : grant_id_r + IDW'(1);
  assign apply_baud_s = (state_r == ST_IDLE) && pend_flag_r;

  // Next-state decode, consume pulse and capture/pointer/timer controls
  always_comb begin
    state_s     = state_r;
    req_ready_s = {NUM_REQ{1'b0}};
    load_s      = 1'b0;
    load_idx_s  = grant_id_r;
    ptr_adv_s   = 1'b0;
    tmo_clr_s   = 1'b0;
    tmo_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arb_any_s) begin
          req_ready_s = arb_grant_s;
          load_s      = 1'b1;
          load_idx_s  = arb_idx_s;
          state_s     = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (ACK_TRMT) begin
          state_s = ST_WAIT_DONE;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done && last_r) begin
          state_s   = ST_IDLE;
          ptr_adv_s = 1'b1;
        end else if (tx_done) begin
          state_s   = ST_HOLD;
          tmo_clr_s = 1'b1;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      ST_HOLD: begin
        // Only the lock owner may continue; everyone else waits
        if (req_valid[grant_id_r]) begin
          req_ready_s[grant_id_r] = 1'b1;
          load_s                  = 1'b1;
          state_s                 = ST_SEND;
        end else if (tmo_cnt_r == LOCK_TIMEOUT - 16'd1) begin
          state_s   = ST_IDLE;
          ptr_adv_s = 1'b1;
        end else begin
          tmo_inc_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, granted byte capture and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= {IDW{1'b0}};
      grant_id_r <= {IDW{1'b0}};
      tx_data_r  <= 8'h00;
      last_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        grant_id_r <= load_idx_s;
        tx_data_r  <= req_data[{load_idx_s, 3'b000} +: 8];
        last_r     <= req_last[load_idx_s];
      end
      if (ptr_adv_s) begin
        rr_ptr_r <= next_ptr_s;
      end
    end
  end

  // Inactivity counter that releases a stalled packet lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (tmo_clr_s) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (tmo_inc_s) begin
      tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end
  end

  // Baud divisor: writes are parked and only committed while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_baud_r <= BAUD_RESET;
      pend_flag_r <= 1'b0;
      baud_r      <= BAUD_RESET;
    end else begin
      if (cfg_baud_we) begin
        pend_baud_r <= cfg_baud_wdata;
        pend_flag_r <= 1'b1;
      end else if (apply_baud_s) begin
        pend_flag_r <= 1'b0;
      end
      if (apply_baud_s) begin
        baud_r <= pend_baud_r;
      end
    end
  end

  // The consume pulse is a same-cycle handshake; it is suppressed during reset
  assign req_ready = req_ready_s & {NUM_REQ{rst_n}};
  assign trmt      = (state_r == ST_SEND);
  assign busy      = (state_r != ST_IDLE);
  assign tx_data   = tx_data_r;
  assign baud_DB   = baud_r;
  assign grant_id  = grant_id_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (2 requesters, short lock timeout).
module tb_uart_tx_sched;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        ACK_TRMT;
  logic        tx_done;
  logic        cfg_baud_we;
  logic [12:0] cfg_baud_wdata;
  logic [12:0] baud_DB;
  logic [0:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  bit   drv_en = 1'b0;
  logic drv_ack, drv_done, man_ack, man_done;
  logic [7:0]  log_data[$];
  logic [12:0] log_baud[$];
  int          log_gid[$];
  logic [8:0]  q0[$];
  logic [8:0]  q1[$];

  assign ACK_TRMT = drv_en ? drv_ack  : man_ack;
  assign tx_done  = drv_en ? drv_done : man_done;

  uart_tx_sched #(.NUM_REQ(2), .BAUD_RESET(13'd434), .LOCK_TIMEOUT(16'd16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .trmt(trmt), .tx_data(tx_data),
    .ACK_TRMT(ACK_TRMT), .tx_done(tx_done), .cfg_baud_we(cfg_baud_we),
    .cfg_baud_wdata(cfg_baud_wdata), .baud_DB(baud_DB), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural TX driver: random accept and frame latency, logs what it loads
  initial begin
    drv_ack = 1'b0;
    drv_done = 1'b0;
    forever begin
      tick();
      if (drv_en && trmt) begin
        repeat ($urandom_range(0, 2)) tick();
        log_data.push_back(tx_data);
        log_baud.push_back(baud_DB);
        log_gid.push_back(int'(grant_id));
        drv_ack = 1'b1;
        tick();
        drv_ack = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        drv_done = 1'b1;
        tick();
        drv_done = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Plays q0/q1 as always-valid requesters and compares the TX byte order
  // against packet-level round robin computed from the queues themselves.
  task automatic run_stream(input string name, input logic [12:0] exp_baud);
    logic [8:0] m0[$];
    logic [8:0] m1[$];
    logic [7:0] exp_d[$];
    int         exp_g[$];
    logic [8:0] b, h0, h1;
    int p, i, cyc, n;
    bit done, granted;
    m0 = q0; m1 = q1; p = model_ptr;
    while (m0.size() + m1.size() > 0) begin
      if (p == 0) i = (m0.size() > 0) ? 0 : 1;
      else        i = (m1.size() > 0) ? 1 : 0;
      done = 1'b0;
      while (!done) begin
        b = (i == 0) ? m0.pop_front() : m1.pop_front();
        exp_d.push_back(b[7:0]);
        exp_g.push_back(i);
        done = b[8];
      end
      p = (i + 1) % 2;
    end
    log_data.delete(); log_baud.delete(); log_gid.delete();
    drv_en = 1'b1;
    cyc = 0;
    granted = 1'b0;
    while ((q0.size() + q1.size() > 0 || busy || granted) && cyc < 4000) begin
      tick();
      h0 = (q0.size() > 0) ? q0[0] : 9'h000;
      h1 = (q1.size() > 0) ? q1[0] : 9'h000;
      req_valid = {q1.size() > 0, q0.size() > 0};
      req_data  = {h1[7:0], h0[7:0]};
      req_last  = {h1[8], h0[8]};
      #1;
      checks++;
      if (((req_ready & (req_ready - 2'd1)) != 2'b00) || ((req_ready & ~req_valid) != 2'b00)) begin
        errors++;
        $display("FAIL %s ready_onehot: got %b valid %b", name, req_ready, req_valid);
      end
      granted = (req_ready != 2'b00);
      if (req_ready[0]) void'(q0.pop_front());
      if (req_ready[1]) void'(q1.pop_front());
      cyc++;
    end
    req_valid = 2'b00;
    drv_en = 1'b0;
    checks++;
    if (cyc >= 4000 || log_data.size() != exp_d.size()) begin
      errors++;
      $display("FAIL %s count: got %0d bytes expected %0d (cycles %0d)", name, log_data.size(), exp_d.size(), cyc);
    end
    n = (log_data.size() < exp_d.size()) ? log_data.size() : exp_d.size();
    for (int k = 0; k < n; k++) begin
      checks++;
      if (log_data[k] !== exp_d[k] || log_gid[k] != exp_g[k] || log_baud[k] !== exp_baud) begin
        errors++;
        $display("FAIL %s byte%0d: got %h/g%0d/b%0d expected %h/g%0d/b%0d", name, k,
                 log_data[k], log_gid[k], log_baud[k], exp_d[k], exp_g[k], exp_baud);
      end
    end
    model_ptr = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b00; req_data = 16'h0000; req_last = 2'b00;
    cfg_baud_we = 1'b0; cfg_baud_wdata = 13'd0;
    man_ack = 1'b0; man_done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (trmt !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || req_ready !== 2'b00 ||
        baud_DB !== 13'd434 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL reset: got trmt %b busy %b data %h ready %b baud %0d gid %b",
               trmt, busy, tx_data, req_ready, baud_DB, grant_id);
    end
    model_ptr = 0;
  endtask

  task automatic test_single();
    tick();
    req_valid = 2'b01; req_data = 16'h00A5; req_last = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (trmt !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
        errors++; $display("FAIL single_send: got trmt %b data %h expected 1 a5", trmt, tx_data);
      end
      if (k == 0) tick();
    end
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    checks++;
    if (trmt !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_wait: got trmt %b busy %b expected 0 1", trmt, busy); end
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b expected 0", busy); end
    model_ptr = 1;
  endtask

  task automatic test_round_robin();
    q0.delete(); q1.delete();
    for (int k = 0; k < 4; k++) begin
      q0.push_back({1'b1, 8'h11});
      q1.push_back({1'b1, 8'h22});
    end
    run_stream("round_robin", 13'd434);
  endtask

  task automatic test_packet_lock();
    q0.delete(); q1.delete();
    q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
    q1.push_back({1'b1, 8'hB1}); q1.push_back({1'b1, 8'hB2});
    run_stream("packet_lock", 13'd434);
  endtask

  task automatic test_random();
    int npk, len;
    for (int it = 0; it < 4; it++) begin
      q0.delete(); q1.delete();
      for (int r = 0; r < 2; r++) begin
        npk = $urandom_range(1, 3);
        for (int pk = 0; pk < npk; pk++) begin
          len = $urandom_range(1, 3);
          for (int bi = 0; bi < len; bi++) begin
            if (r == 0) q0.push_back({bi == len - 1, 8'($urandom)});
            else        q1.push_back({bi == len - 1, 8'($urandom)});
          end
        end
      end
      run_stream("random", 13'd434);
    end
  endtask

  task automatic test_timeout();
    tick();
    req_valid = 2'b01; req_data = 16'h7E3C; req_last = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL timeout_grant0: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b10;
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++; $display("FAIL timeout_hold%0d: got ready %b busy %b expected 00 1", k, req_ready, busy);
      end
      tick();
    end
    #1;
    checks++;
    if (req_ready !== 2'b10 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_release: got ready %b busy %b expected 10 0", req_ready, busy);
    end
    tick();
    req_valid = 2'b00;
    checks++;
    if (trmt !== 1'b1 || tx_data !== 8'h7E || grant_id !== 1'b1) begin
      errors++; $display("FAIL timeout_send1: got trmt %b data %h gid %b expected 1 7e 1", trmt, tx_data, grant_id);
    end
    man_ack = 1'b1; tick(); man_ack = 1'b0;
    man_done = 1'b1; tick(); man_done = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_baud();
    req_data = 16'h0055; req_last = 2'b01;
    tick(); req_valid = 2'b01;
    tick(); req_valid = 2'b00;
    man_ack = 1'b1; tick(); man_ack = 1'b0;
    cfg_baud_we = 1'b1; cfg_baud_wdata = 13'd27;
    tick(); cfg_baud_we = 1'b0;
    checks++;
    if (baud_DB !== 13'd434) begin errors++; $display("FAIL baud_defer: got %0d expected 434", baud_DB); end
    man_done = 1'b1; tick(); man_done = 1'b0;
    checks++;
    if (baud_DB !== 13'd434 || busy !== 1'b0) begin errors++; $display("FAIL baud_idle0: got %0d busy %b expected 434 0", baud_DB, busy); end
    tick();
    checks++;
    if (baud_DB !== 13'd27) begin errors++; $display("FAIL baud_apply: got %0d expected 27", baud_DB); end
    // two writes while busy: the later one wins
    tick(); req_valid = 2'b01;
    tick(); req_valid = 2'b00; cfg_baud_we = 1'b1; cfg_baud_wdata = 13'd100;
    tick(); cfg_baud_wdata = 13'd54;
    tick(); cfg_baud_we = 1'b0; man_ack = 1'b1;
    tick(); man_ack = 1'b0; man_done = 1'b1;
    tick(); man_done = 1'b0;
    checks++;
    if (baud_DB !== 13'd27) begin errors++; $display("FAIL baud_hold27: got %0d expected 27", baud_DB); end
    tick();
    checks++;
    if (baud_DB !== 13'd54) begin errors++; $display("FAIL baud_last_wins: got %0d expected 54", baud_DB); end
    // write while idle, grant on the commit cycle: driver load sees the new value
    tick(); cfg_baud_we = 1'b1; cfg_baud_wdata = 13'd99;
    tick(); cfg_baud_we = 1'b0; req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01 || baud_DB !== 13'd54) begin
      errors++; $display("FAIL baud_grant_cycle: got ready %b baud %0d expected 01 54", req_ready, baud_DB);
    end
    tick(); req_valid = 2'b00;
    checks++;
    if (trmt !== 1'b1 || baud_DB !== 13'd99) begin errors++; $display("FAIL baud_at_load: got trmt %b baud %0d expected 1 99", trmt, baud_DB); end
    man_ack = 1'b1; tick(); man_ack = 1'b0;
    man_done = 1'b1; tick(); man_done = 1'b0;
    model_ptr = 1;
  endtask

  task automatic test_reset_mid();
    req_data = 16'h0066; req_last = 2'b01;
    tick(); req_valid = 2'b01;
    tick(); req_valid = 2'b00;
    man_ack = 1'b1; tick(); man_ack = 1'b0;
    cfg_baud_we = 1'b1; cfg_baud_wdata = 13'd27;
    tick(); cfg_baud_we = 1'b0;
    req_valid = 2'b01;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (trmt !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || req_ready !== 2'b00 ||
        baud_DB !== 13'd434 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got trmt %b busy %b data %h ready %b baud %0d gid %b",
               trmt, busy, tx_data, req_ready, baud_DB, grant_id);
    end
    tick(); req_valid = 2'b00;
    tick(); rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      man_done = (k == 3);
      tick();
      checks++;
      if (trmt !== 1'b0 || busy !== 1'b0 || baud_DB !== 13'd434) begin
        errors++; $display("FAIL reset_after%0d: got trmt %b busy %b baud %0d expected 0 0 434", k, trmt, busy, baud_DB);
      end
    end
    man_done = 1'b0;
    model_ptr = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_random();
    test_timeout();
    test_baud();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
